proc_sequencer: RTL
===================

Name: proc_sequencer

Overview:
Control unit for the 10-bit processor datapath. It fetches one instruction word on an EXEC request and walks it through timesteps T0-T3. In each timestep it drives the datapath's load, bus-drive and ALU controls, then signals DONE.

Parameters:
IW, 10, instruction width; only 10 is supported, and any other value must raise an elaboration error.
NREG, 4, number of general registers; only 4 is supported, matching the 2-bit register fields.

Ports:
CLK  input  1  system clock, rising edge.
CLR  input  1  reset, asynchronous, active-high.
EXEC  input  1  execute request; sampled only in T0.
INSTR  input  10  instruction word; valid when EXEC=1.
IR_LD  output  1  load instruction register (internal IR copy).
RIN  output  4  per-register load enables; one-hot or zero.
ROUT  output  4  per-register bus-drive enables; one-hot or zero.
EXTRN  output  1  drive the external data input onto the bus.
A_LD  output  1  load the ALU A operand register.
G_LD  output  1  load the ALU result register G.
G_OUT  output  1  drive G onto the bus.
ALU_FN  output  4  ALU function select.
DONE  output  1  instruction complete; 1-cycle pulse.
BUSY  output  1  high whenever TSTEP != T0.
TSTEP  output  2  current timestep, for debug and performance counting.

Behaviour:
- Instruction format:
  - opcode = INSTR[9:8]: 00 LOAD, 01 MOV, 10 ALU, 11 NOP.
  - fn = INSTR[7:4].
  - rx = INSTR[3:2].
  - ry = INSTR[1:0].
- State:
  - TSTEP is a 2-bit register.
  - IR is a 10-bit register, loaded only when IR_LD=1 on a CLK edge.
- Reset: CLR=1 forces TSTEP=0 and IR=0 immediately, independent of CLK. All outputs read 0 while CLR=1, including IR_LD regardless of EXEC.
- Outputs are combinational decodes of (TSTEP, IR, EXEC). All outputs not listed for a step are 0.
- T0, idle:
  - IR_LD = EXEC.
  - If EXEC=1, next TSTEP=T1; otherwise hold T0.
- T1, decoding IR:
  - LOAD: EXTRN=1, RIN[rx]=1, DONE=1; next T0.
  - MOV: ROUT[ry]=1, RIN[rx]=1, DONE=1; next T0.
  - ALU: ROUT[rx]=1, A_LD=1; next T2.
  - NOP: DONE=1 only; next T0.
- T2 (ALU only): ROUT[ry]=1, G_LD=1, ALU_FN=fn; next T3.
- T3 (ALU only): G_OUT=1, RIN[rx]=1, DONE=1; next T0.
- Latency from the EXEC edge to DONE:
  - LOAD, MOV and NOP: DONE is high in the cycle after the fetch edge (2 cycles total).
  - ALU: DONE is high in the third cycle after the fetch edge (4 cycles total).
- Back-to-back operation: EXEC may be high in the T0 cycle that immediately follows DONE. Sustained throughput is one MOV every 2 cycles.
- EXEC and INSTR are ignored in T1-T3. A held EXEC fetches again as soon as T0 is reached.
- CLR asserted mid-instruction aborts it: no DONE is produced, and no partial write is issued after the reset edge.
- MOV with rx=ry is legal: ROUT[n] and RIN[n] are high together.
- TSTEP wraps T3 to T0 only via DONE. TSTEP must never wrap from T1 or T2.
- Invariant, asserted in simulation: at most one of {ROUT[3:0], EXTRN, G_OUT} is high in any cycle (single bus driver).
- ALU_FN is 0 outside T2.

Decomposition:
- Package proc_pkg holds:
  - enum opcode_t {OP_LOAD, OP_MOV, OP_ALU, OP_NOP} (2 bits).
  - enum tstep_t {T0, T1, T2, T3}.
  - Field bit positions OPC_HI/LO, FN_HI/LO, RX_HI/LO, RY_HI/LO.
  - A function onehot4(2-bit) returning a 4-bit vector.
- One sub-module, tstep_ctr: 2-bit counter with async CLR, synchronous clear input and increment enable. The sequencer drives increment = (T0 & EXEC) | (T1 & ALU) | T2, and clear = DONE.
- Decode and output logic live in proc_sequencer.

Test Plan:
- CLR pulse mid-T2 of an ALU instruction -> TSTEP=0, BUSY=0, all outputs 0 before the next CLK edge; DONE never pulses for that instruction.
- EXEC=1, INSTR=00_0000_10_00 (LOAD R2) -> T0: IR_LD=1; T1: EXTRN=1, RIN=0100, DONE=1; then TSTEP=0.
- EXEC=1, INSTR=01_0000_01_11 (MOV R1,R3) -> T1: ROUT=1000, RIN=0010, DONE=1; total 2 cycles.
- EXEC=1, INSTR=10_0101_00_01 (ALU fn=5, R0,R1):
  - T1: ROUT=0001, A_LD=1.
  - T2: ROUT=0010, G_LD=1, ALU_FN=0101.
  - T3: G_OUT=1, RIN=0001, DONE=1.
- EXEC held high across a 4-cycle ALU instruction with INSTR changing in T1-T3 -> IR is unchanged until the next T0; the next fetch occurs in the cycle after DONE.
- Random 10k-instruction stream with random EXEC gaps:
  - Single-bus-driver and RIN one-hot assertions never fire.
  - DONE count equals the number of accepted instructions.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: shared types and field positions for the 10-bit processor control unit.
//   opcode_t  - instruction opcode (INSTR[9:8])
//   tstep_t   - sequencer timestep
//   *_HI/_LO  - instruction field bit positions
//   onehot4   - 2-bit register number to 4-bit one-hot enable
package proc_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_MOV  = 2'b01,
    OP_ALU  = 2'b10,
    OP_NOP  = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  localparam int OPC_HI = 9;
  localparam int OPC_LO = 8;
  localparam int FN_HI  = 7;
  localparam int FN_LO  = 4;
  localparam int RX_HI  = 3;
  localparam int RX_LO  = 2;
  localparam int RY_HI  = 1;
  localparam int RY_LO  = 0;

  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    onehot4 = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/proc_sequencer_tstep_ctr.sv
// tstep_ctr: 2-bit timestep counter.
//   CLK   - rising-edge clock
//   CLR   - asynchronous active-high reset to 0
//   clr   - synchronous clear (wins over inc)
//   inc   - increment enable
//   q     - current count
module tstep_ctr (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       clr,
  input  logic       inc,
  output logic [1:0] q
);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)      q <= 2'd0;
    else if (clr) q <= 2'd0;
    else if (inc) q <= q + 2'd1;
  end

endmodule

// File: rtl/proc_sequencer.sv
// proc_sequencer: control unit for the 10-bit datapath. Fetches an instruction on
// EXEC in T0 and steps it through T1..T3, driving register/bus/ALU controls.
//   CLK, CLR        - clock, asynchronous active-high reset
//   EXEC, INSTR     - execute request and instruction word (used in T0 only)
//   IR_LD           - instruction register load
//   RIN, ROUT       - per-register load / bus-drive enables (one-hot or zero)
//   EXTRN, G_OUT    - external input / G register bus drive
//   A_LD, G_LD      - ALU operand / result register loads
//   ALU_FN          - ALU function (nonzero only in T2)
//   DONE            - 1-cycle instruction-complete pulse
//   BUSY, TSTEP     - not-idle flag and current timestep
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int IW   = 10,
  parameter int NREG = 4
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            EXEC,
  input  logic [IW-1:0]   INSTR,
  output logic            IR_LD,
  output logic [NREG-1:0] RIN,
  output logic [NREG-1:0] ROUT,
  output logic            EXTRN,
  output logic            A_LD,
  output logic            G_LD,
  output logic            G_OUT,
  output logic [3:0]      ALU_FN,
  output logic            DONE,
  output logic            BUSY,
  output logic [1:0]      TSTEP
);

  if (IW != 10) begin : g_bad_iw
    $error("proc_sequencer: IW must be 10");
  end
  if (NREG != 4) begin : g_bad_nreg
    $error("proc_sequencer: NREG must be 4");
  end

  logic [IW-1:0] ir;
  logic [1:0]    tq;
  logic          inc;
  tstep_t        ts;
  opcode_t       opc;
  logic [3:0]    fn;
  logic [1:0]    rx, ry;

  assign ts  = tstep_t'(tq);
  assign opc = opcode_t'(ir[OPC_HI:OPC_LO]);
  assign fn  = ir[FN_HI:FN_LO];
  assign rx  = ir[RX_HI:RX_LO];
  assign ry  = ir[RY_HI:RY_LO];

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)        ir <= '0;
    else if (IR_LD) ir <= INSTR;
  end

  // DONE doubles as the synchronous clear, so T3 (and short ops in T1) return
  // to T0 through the clear path; the counter never wraps by incrementing.
  tstep_ctr u_ctr (
    .CLK (CLK),
    .CLR (CLR),
    .clr (DONE),
    .inc (inc),
    .q   (tq)
  );

  always_comb begin
    IR_LD  = 1'b0;
    RIN    = '0;
    ROUT   = '0;
    EXTRN  = 1'b0;
    A_LD   = 1'b0;
    G_LD   = 1'b0;
    G_OUT  = 1'b0;
    ALU_FN = 4'd0;
    DONE   = 1'b0;
    inc    = 1'b0;
    // CLR gating keeps IR_LD (driven straight from EXEC) quiet during reset.
    if (!CLR) begin
      unique case (ts)
        T0: begin
          IR_LD = EXEC;
          inc   = EXEC;
        end
        T1: begin
          unique case (opc)
            OP_LOAD: begin
              EXTRN = 1'b1;
              RIN   = onehot4(rx);
              DONE  = 1'b1;
            end
            OP_MOV: begin
              ROUT = onehot4(ry);
              RIN  = onehot4(rx);
              DONE = 1'b1;
            end
            OP_ALU: begin
              ROUT = onehot4(rx);
              A_LD = 1'b1;
              inc  = 1'b1;
            end
            OP_NOP: DONE = 1'b1;
          endcase
        end
        T2: begin
          ROUT   = onehot4(ry);
          G_LD   = 1'b1;
          ALU_FN = fn;
          inc    = 1'b1;
        end
        T3: begin
          G_OUT = 1'b1;
          RIN   = onehot4(rx);
          DONE  = 1'b1;
        end
      endcase
    end
  end

  assign BUSY  = (ts != T0);
  assign TSTEP = tq;

  a_one_driver: assert property (@(posedge CLK) disable iff (CLR)
    $onehot0({ROUT, EXTRN, G_OUT}));
  a_rin_onehot: assert property (@(posedge CLK) disable iff (CLR)
    $onehot0(RIN));

endmodule
